// File: rtl/sram_ctrl_defs.sv
// sram_ctrl_defs: shared state encoding, default geometry and width helper for the SRAM controller
package sram_ctrl_defs;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } state_t;

    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int DEF_WORD_W   = 32;
    localparam int DEF_DQ_W     = 16;
    localparam int DEF_SRAM_AW  = 18;
    localparam int DEF_WAIT_CYC = 2;
    localparam int BEATS        = DEF_WORD_W / DEF_DQ_W;
    localparam int BEAT_W       = clog2_min1(BEATS);
    localparam int WAIT_W       = clog2_min1(DEF_WAIT_CYC + 1);

endpackage

// File: rtl/sram_beat_timer.sv
// sram_beat_timer: sub-cycle and beat counters pacing one multi-beat SRAM access
module sram_beat_timer
    import sram_ctrl_defs::*;
#(
    parameter int N_BEATS  = BEATS,
    parameter int WAIT_CYC = DEF_WAIT_CYC,
    parameter int CNT_BW   = BEAT_W,
    parameter int CNT_WW   = WAIT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    output logic              setup,
    output logic              last_sub,
    output logic              last_beat,
    output logic [CNT_BW-1:0] beat
);

    logic [CNT_WW-1:0] sub;

    assign setup     = (sub == '0);
    assign last_sub  = (sub == CNT_WW'(WAIT_CYC));
    assign last_beat = (beat == CNT_BW'(N_BEATS - 1));

    // counters sit at zero while idle so every access starts on beat 0, sub-cycle 0
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sub  <= '0;
            beat <= '0;
        end else if (!run) begin
            sub  <= '0;
            beat <= '0;
        end else if (last_sub) begin
            sub  <= '0;
            beat <= last_beat ? '0 : beat + 1'b1;
        end else begin
            sub <= sub + 1'b1;
        end
    end

endmodule

// File: rtl/sram_ctrl_gen.sv
// sram_ctrl_gen: MEM-stage to narrow asynchronous SRAM controller with wait states and byte strobes
module sram_ctrl_gen
    import sram_ctrl_defs::*;
#(
    parameter int          WORD_W    = DEF_WORD_W,
    parameter int          DQ_W      = DEF_DQ_W,
    parameter int          SRAM_AW   = DEF_SRAM_AW,
    parameter int          WAIT_CYC  = DEF_WAIT_CYC,
    parameter logic [31:0] BASE_ADDR = 32'h0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [31:0]         req_addr,
    input  logic [WORD_W-1:0]   req_wdata,
    input  logic [WORD_W/8-1:0] req_be,
    output logic                rsp_valid,
    output logic [WORD_W-1:0]   rsp_rdata,
    output logic                stall,
    inout  wire  [DQ_W-1:0]     SRAM_DQ,
    output logic [SRAM_AW-1:0]  SRAM_ADDR,
    output logic                SRAM_WE_N,
    output logic [DQ_W/8-1:0]   SRAM_BE_N
);

    localparam int N_BEATS = WORD_W / DQ_W;
    localparam int LANES   = DQ_W / 8;
    localparam int CNT_BW  = clog2_min1(N_BEATS);
    localparam int CNT_WW  = clog2_min1(WAIT_CYC + 1);
    localparam int BYTE_SH = $clog2(LANES);
    localparam int BEAT_SH = $clog2(N_BEATS);

    state_t                state, state_nx;
    logic                  we_q;
    logic [SRAM_AW-1:0]    loc_q;
    logic [WORD_W-1:0]     wdata_q;
    logic [WORD_W/8-1:0]   be_q;
    logic [WORD_W-1:0]     rd_buf, rd_nx;
    logic                  setup, last_sub, last_beat;
    logic [CNT_BW-1:0]     beat;
    logic                  accept, busy, wr_act, rd_cap;
    logic [DQ_W-1:0]       wr_slice;
    logic [LANES-1:0]      be_slice;

    sram_beat_timer #(
        .N_BEATS (N_BEATS),
        .WAIT_CYC(WAIT_CYC),
        .CNT_BW  (CNT_BW),
        .CNT_WW  (CNT_WW)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .run      (busy),
        .setup    (setup),
        .last_sub (last_sub),
        .last_beat(last_beat),
        .beat     (beat)
    );

    assign req_ready = (state == IDLE);
    assign rsp_valid = (state == DONE);
    assign busy      = (state == ACCESS);
    assign accept    = req_valid & req_ready;
    assign stall     = req_valid & ~rsp_valid;
    assign wr_act    = busy & we_q;
    assign rd_cap    = busy & ~we_q & last_sub;
    assign wr_slice  = wdata_q[int'(beat) * DQ_W +: DQ_W];
    assign be_slice  = be_q[int'(beat) * LANES +: LANES];

    // beat address wraps naturally at the top of the SRAM
    assign SRAM_ADDR = loc_q + SRAM_AW'(beat);
    // strobe only after the setup sub-cycle, and never for a beat with no enabled bytes
    assign SRAM_WE_N = ~(wr_act & ~setup & |be_slice);
    // lanes stay disabled outside accesses and during write setup; reads enable every lane
    assign SRAM_BE_N = busy ? (we_q ? (setup ? '1 : ~be_slice) : '0) : '1;
    // DQ is released in IDLE and DONE, leaving a turnaround cycle between accesses
    assign SRAM_DQ   = wr_act ? wr_slice : 'z;

    // merge the current beat's DQ into the partially assembled read word
    always_comb begin
        rd_nx = rd_buf;
        rd_nx[int'(beat) * DQ_W +: DQ_W] = SRAM_DQ;
    end

    // state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    // next-state logic: one access per accept, one response cycle
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = accept ? ACCESS : IDLE;
            ACCESS:  state_nx = (last_sub && last_beat) ? DONE : ACCESS;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // request fields are frozen at accept so later input changes cannot disturb the access
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            we_q    <= 1'b0;
            loc_q   <= '0;
            wdata_q <= '0;
            be_q    <= '0;
        end else if (accept) begin
            we_q    <= req_we;
            loc_q   <= SRAM_AW'(((req_addr - BASE_ADDR) >> (BYTE_SH + BEAT_SH)) << BEAT_SH);
            wdata_q <= req_wdata;
            be_q    <= req_be;
        end
    end

    // read beats land in the assembly buffer; the final beat publishes the whole word for DONE
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_buf    <= '0;
            rsp_rdata <= '0;
        end else if (rd_cap) begin
            rd_buf <= rd_nx;
            if (last_beat) rsp_rdata <= rd_nx;
        end
    end

endmodule

// File: tb/tb_sram_ctrl_gen.sv
// tb_sram_ctrl_gen: directed and random accesses against an SRAM model and a word-level scoreboard
module tb_sram_ctrl_gen;

    localparam int MEM_N = 262144;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [3:0]  req_be = '0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        stall;
    tri1  [15:0] dq_bus;
    logic [17:0] sram_addr;
    logic        we_n;
    logic [1:0]  be_n;

    int n_chk = 0;
    int n_err = 0;
    logic [31:0] last_rd = '0;

    logic [15:0] mem [int];
    logic [15:0] ref_mem [int];
    logic [15:0] rd_val = '0;
    logic        drv;

    sram_ctrl_gen dut (
        .clk      (clk),
        .rst      (rst),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_we   (req_we),
        .req_addr (req_addr),
        .req_wdata(req_wdata),
        .req_be   (req_be),
        .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata),
        .stall    (stall),
        .SRAM_DQ  (dq_bus),
        .SRAM_ADDR(sram_addr),
        .SRAM_WE_N(we_n),
        .SRAM_BE_N(be_n)
    );

    always #5 clk = ~clk;

    // asynchronous SRAM: outputs data while not writing and some lane is enabled
    assign drv    = (we_n === 1'b1) && (be_n !== 2'b11);
    assign dq_bus = drv ? rd_val : 16'bz;

    always @(negedge clk) begin
        logic [15:0] w;
        int a;
        a = int'(sram_addr);
        if (we_n === 1'b0) begin
            w = mem.exists(a) ? mem[a] : 16'h0;
            for (int l = 0; l < 2; l++)
                if (be_n[l] === 1'b0) w[8*l +: 8] = dq_bus[8*l +: 8];
            mem[a] = w;
        end
        rd_val <= mem.exists(a) ? mem[a] : 16'h0;
    end

    function automatic logic [15:0] ref_rd(input int a);
        return ref_mem.exists(a) ? ref_mem[a] : 16'h0;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // one complete access; expectations come from word address arithmetic and the byte-level scoreboard
    task automatic txn(input bit we, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [3:0] be, input bit hold);
        int base, k, s, loc;
        logic [1:0]  bs;
        logic [15:0] w;
        base = int'(addr >> 2) * 2;
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wd;
        req_be    = be;
        #1;
        check("ready_idle", {63'b0, req_ready}, 64'd1);
        check("stall_req", {63'b0, stall}, 64'd1);
        @(posedge clk);
        #1;
        if (!hold) req_valid = 1'b0;
        req_we    = 1'($urandom);
        req_addr  = $urandom;
        req_wdata = $urandom;
        req_be    = 4'($urandom);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            k   = i / 3;
            s   = i % 3;
            loc = (base + k) % MEM_N;
            bs  = be[2*k +: 2];
            check("addr", {46'b0, sram_addr}, 64'(loc));
            check("we_n", {63'b0, we_n}, (we && s > 0 && bs != 2'b00) ? 64'd0 : 64'd1);
            if (we) check("dq_wr", {48'b0, dq_bus}, {48'b0, wd[16*k +: 16]});
            if (we && s > 0) check("be_n_wr", {62'b0, be_n}, {62'b0, ~bs});
            if (!we) check("be_n_rd", {62'b0, be_n}, 64'd0);
            check("rsp_busy", {63'b0, rsp_valid}, 64'd0);
            check("ready_busy", {63'b0, req_ready}, 64'd0);
            check("stall_busy", {63'b0, stall}, {63'b0, hold});
        end
        if (we) begin
            for (int b = 0; b < 2; b++)
                for (int l = 0; l < 2; l++)
                    if (be[2*b + l]) begin
                        loc = (base + b) % MEM_N;
                        w = ref_rd(loc);
                        w[8*l +: 8] = wd[16*b + 8*l +: 8];
                        ref_mem[loc] = w;
                    end
        end else begin
            last_rd = {ref_rd((base + 1) % MEM_N), ref_rd(base % MEM_N)};
        end
        @(negedge clk);
        check("rsp_done", {63'b0, rsp_valid}, 64'd1);
        check("rdata", {32'b0, rsp_rdata}, {32'b0, last_rd});
        check("dq_done_z", {48'b0, dq_bus}, 64'hFFFF);
        check("stall_done", {63'b0, stall}, 64'd0);
        check("ready_done", {63'b0, req_ready}, 64'd0);
        req_valid = 1'b0;
        @(negedge clk);
        check("rsp_after", {63'b0, rsp_valid}, 64'd0);
        check("ready_after", {63'b0, req_ready}, 64'd1);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_we_n", {63'b0, we_n}, 64'd1);
        check("rst_be_n", {62'b0, be_n}, 64'h3);
        check("rst_dq_z", {48'b0, dq_bus}, 64'hFFFF);
        check("rst_ready", {63'b0, req_ready}, 64'd1);
        check("rst_rsp", {63'b0, rsp_valid}, 64'd0);
        check("rst_rdata", {32'b0, rsp_rdata}, 64'd0);
        check("rst_addr", {46'b0, sram_addr}, 64'd0);
        rst = 1'b1;

        txn(1'b1, 32'h8, 32'hDEADBEEF, 4'hF, 1'b0);
        txn(1'b0, 32'h8, 32'h0, 4'h0, 1'b0);
        txn(1'b1, 32'h8, 32'h12345678, 4'b0010, 1'b1);
        txn(1'b0, 32'hB, 32'h0, 4'hF, 1'b1);
        txn(1'b1, 32'h7FFFC, 32'hCAFEF00D, 4'hF, 1'b0);
        txn(1'b1, 32'h80000, 32'h0BAD1DEA, 4'b1001, 1'b0);
        txn(1'b0, 32'h7FFFC, 32'h0, 4'h0, 1'b0);
        txn(1'b0, 32'h0, 32'h0, 4'h0, 1'b0);

        for (int n = 0; n < 40; n++)
            txn(1'($urandom), 32'h100 + 32'($urandom_range(0, 63)), $urandom,
                4'($urandom), 1'($urandom));

        @(negedge clk);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 32'h1000;
        req_wdata = 32'h55AA55AA;
        req_be    = 4'hF;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("abort_pre_we_n", {63'b0, we_n}, 64'd0);
        #2 rst = 1'b0;
        #1;
        check("abort_we_n", {63'b0, we_n}, 64'd1);
        check("abort_be_n", {62'b0, be_n}, 64'h3);
        check("abort_dq_z", {48'b0, dq_bus}, 64'hFFFF);
        check("abort_ready", {63'b0, req_ready}, 64'd1);
        check("abort_rsp", {63'b0, rsp_valid}, 64'd0);
        repeat (3) begin
            @(negedge clk);
            check("abort_no_rsp", {63'b0, rsp_valid}, 64'd0);
        end
        rst = 1'b1;
        last_rd = 32'h0;
        txn(1'b1, 32'h20, 32'hA1B2C3D4, 4'hF, 1'b0);
        txn(1'b0, 32'h20, 32'h0, 4'h0, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
